pc_sequencer: RTL and testbench

Program-counter sequencer that consumes the processor's combinational jump table. It drives the 3-bit jump pointer taken from a branch instruction, receives the 6-bit target address, and advances, branches or halts the PC. It sits between instruction decode and instruction ROM. It also owns the Start/Done program handshake and flags branches that resolve to the table's error address (63).

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer driving the combinational jump table
// Start/Done handshake, conditional branches, halt, and fault on the table's error address.
module pc_sequencer #(
   parameter int PC_W     = 6,
   parameter int PTR_W    = 3,
   parameter int ERR_ADDR = 63,
   parameter int CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stall,
   input  logic             BranchEn,
   input  logic             CondTrue,
   input  logic [PTR_W-1:0] BranchPtr,
   input  logic             HaltInstr,
   input  logic [PC_W-1:0]  Jump,
   output logic [PTR_W-1:0] Jptr,
   output logic [PC_W-1:0]  PC,
   output logic             Running,
   output logic             Done,
   output logic             Fault,
   output logic [CNT_W-1:0] CycleCount
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAULT} state_t;

   state_t           r_state;
   logic [PC_W-1:0]  r_pc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_running;
   logic             r_done;
   logic             r_fault;

   logic [PC_W-1:0]  w_err;
   logic [PC_W-1:0]  w_pc_inc;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_taken;

   // No register in the pointer path: the table answers within the same cycle.
   assign Jptr       = BranchEn ? BranchPtr : '0;
   assign w_err      = PC_W'(ERR_ADDR);
   assign w_pc_inc   = r_pc + 1'b1;
   assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
   assign w_taken    = BranchEn & CondTrue;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_cnt     <= '0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  r_state   <= S_RUN;
                  r_pc      <= '0;
                  r_cnt     <= '0;
                  r_running <= 1'b1;
                  r_done    <= 1'b0;
               end
            end
            S_RUN: begin
               if (!Stall) begin
                  r_cnt <= w_cnt_next;
                  if (HaltInstr) begin
                     r_state   <= S_DONE;
                     r_running <= 1'b0;
                     r_done    <= 1'b1;
                  end else if (w_taken && (Jump == w_err)) begin
                     r_state   <= S_FAULT;
                     r_running <= 1'b0;
                     r_fault   <= 1'b1;
                  end else if (w_taken) begin
                     r_pc <= Jump;
                  end else if (w_pc_inc == w_err) begin
                     // Running off the end would fetch the error address; stop at the last slot.
                     r_state   <= S_FAULT;
                     r_running <= 1'b0;
                     r_fault   <= 1'b1;
                  end else begin
                     r_pc <= w_pc_inc;
                  end
               end
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign PC         = r_pc;
   assign Running    = r_running;
   assign Done       = r_done;
   assign Fault      = r_fault;
   assign CycleCount = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_pc_sequencer;

   logic        Clk = 1'b0;
   logic        Reset, Start, Stall, BranchEn, CondTrue, HaltInstr;
   logic [2:0]  BranchPtr;
   logic [5:0]  Jump;
   logic [2:0]  Jptr, Jptr4;
   logic [5:0]  PC, PC4;
   logic        Running, Done, Fault;
   logic        Running4, Done4, Fault4;
   logic [15:0] CycleCount;
   logic [3:0]  CycleCount4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   // Jump table model: entry 2 -> 24, entry 6 -> error address, others -> 10.
   always_comb begin
      case (Jptr)
         3'd2:    Jump = 6'd24;
         3'd6:    Jump = 6'd63;
         default: Jump = 6'd10;
      endcase
   end

   pc_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
      .CondTrue(CondTrue), .BranchPtr(BranchPtr), .HaltInstr(HaltInstr), .Jump(Jump),
      .Jptr(Jptr), .PC(PC), .Running(Running), .Done(Done), .Fault(Fault),
      .CycleCount(CycleCount)
   );

   pc_sequencer #(.CNT_W(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
      .CondTrue(CondTrue), .BranchPtr(BranchPtr), .HaltInstr(HaltInstr), .Jump(Jump),
      .Jptr(Jptr4), .PC(PC4), .Running(Running4), .Done(Done4), .Fault(Fault4),
      .CycleCount(CycleCount4)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_inputs();
      Start = 0; Stall = 0; BranchEn = 0; CondTrue = 0; BranchPtr = 0; HaltInstr = 0;
   endtask

   task automatic restart(input int n);
      clear_inputs();
      Reset = 1; step();
      Reset = 0; Start = 1; step();
      Start = 0;
      repeat (n) step();
   endtask

   initial begin
      clear_inputs();
      Reset = 1;
      step(); step();
      chk("rst_pc", PC, 0);
      chk("rst_running", Running, 0);
      chk("rst_done", Done, 0);
      chk("rst_fault", Fault, 0);
      chk("rst_count", CycleCount, 0);
      chk("rst_jptr", Jptr, 0);

      // Start then five sequential instructions
      Reset = 0; Start = 1; step(); Start = 0;
      chk("start_pc", PC, 0);
      chk("start_running", Running, 1);
      chk("start_count", CycleCount, 0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("seq_pc", PC, i);
      end
      chk("seq_count", CycleCount, 5);
      chk("seq_running", Running, 1);

      // Start while running has no effect
      Start = 1; step(); Start = 0;
      chk("start_in_run_pc", PC, 6);

      // Taken branch at PC=3
      restart(3);
      chk("pre_br_pc", PC, 3);
      BranchEn = 1; CondTrue = 1; BranchPtr = 3'd2; #1;
      chk("br_jptr", Jptr, 2);
      chk("br_jump", Jump, 24);
      step(); clear_inputs();
      chk("br_taken_pc", PC, 24);

      // Not-taken branch at PC=3
      restart(3);
      BranchEn = 1; CondTrue = 0; BranchPtr = 3'd2; #1;
      chk("nt_jptr", Jptr, 2);
      step(); clear_inputs();
      chk("br_not_taken_pc", PC, 4);

      // Branch resolving to the error address
      restart(3);
      BranchEn = 1; CondTrue = 1; BranchPtr = 3'd6; #1;
      chk("err_jptr", Jptr, 6);
      step(); clear_inputs();
      chk("err_fault", Fault, 1);
      chk("err_pc", PC, 3);
      chk("err_running", Running, 0);
      Start = 1; step(); Start = 0;
      chk("fault_start_fault", Fault, 1);
      chk("fault_start_pc", PC, 3);
      chk("fault_start_running", Running, 0);
      Reset = 1; step(); Reset = 0;
      chk("fault_rst_pc", PC, 0);
      chk("fault_rst_fault", Fault, 0);
      chk("fault_rst_running", Running, 0);

      // Stall overrides halt and a taken branch
      restart(7);
      chk("pre_stall_pc", PC, 7);
      Stall = 1; HaltInstr = 1; BranchEn = 1; CondTrue = 1; BranchPtr = 3'd2;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", PC, 7);
         chk("stall_count", CycleCount, 7);
         chk("stall_done", Done, 0);
      end
      Stall = 0; BranchEn = 0; CondTrue = 0;
      step(); clear_inputs();
      chk("halt_done", Done, 1);
      chk("halt_pc", PC, 7);
      chk("halt_running", Running, 0);
      chk("halt_count", CycleCount, 8);
      step();
      chk("done_hold_pc", PC, 7);
      chk("done_hold_count", CycleCount, 8);

      // Restart from DONE, then run off the end
      Start = 1; step(); Start = 0;
      chk("redo_pc", PC, 0);
      chk("redo_done", Done, 0);
      chk("redo_count", CycleCount, 0);
      chk("redo_running", Running, 1);
      for (int i = 1; i <= 62; i++) begin
         step();
         chk("run_pc", PC, i);
      end
      chk("run_running", Running, 1);
      step();
      chk("end_fault", Fault, 1);
      chk("end_pc", PC, 62);
      chk("end_count", CycleCount, 63);
      chk("end_count4_sat", CycleCount4, 15);
      chk("end_pc4", PC4, 62);
      step();
      chk("end_hold_pc", PC, 62);
      chk("end_hold_count4", CycleCount4, 15);

      // Reset mid-run, during a stall
      restart(3);
      Stall = 1; Reset = 1; step(); clear_inputs(); Reset = 0;
      chk("midrst_pc", PC, 0);
      chk("midrst_running", Running, 0);
      chk("midrst_count", CycleCount, 0);
      chk("midrst_count4", CycleCount4, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_fault", Fault, 0);
      chk("midrst_jptr4", Jptr4, 0);
      chk("midrst_running4", Running4 | Done4 | Fault4, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
